rom_read_arbiter: RTL and testbench
===================================

ROM_READ_ARBITER -- requirements
Module: rom_read_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 3, number of requesters sharing one ROM read port (2..8).
REQ-002 Parameter ADDR_W, default 8, ROM address width.
REQ-003 Parameter DATA_W, default 24, ROM data width (RGB888 pixel).
REQ-004 Port Clk  input  1  the only clock; all state updates on its rising edge.
REQ-005 Port Reset  input  1  asynchronous, active-high reset.
REQ-006 Port req  input  NUM_REQ  per-requester read request, held high with addr stable until granted.
REQ-007 Port addr  input  NUM_REQ*ADDR_W  flattened request addresses, requester i at bits [i*ADDR_W +: ADDR_W].
REQ-008 Port gnt  output  NUM_REQ  one-hot combinational grant; requester i's request is accepted at the rising edge ending a cycle with gnt[i]=1.
REQ-009 Port rom_addr  output  ADDR_W  address to the shared ROM, which samples it on the Clk rising edge.
REQ-010 Port rom_data  input  DATA_W  ROM registered output, valid one cycle after rom_addr is sampled.
REQ-011 Port rdata  output  DATA_W  registered read data returned to the owning requester.
REQ-012 Port rdata_valid  output  NUM_REQ  one-hot registered; bit i high for exactly one cycle when rdata belongs to requester i.

Function
REQ-013 At most one gnt bit SHALL be high per cycle; gnt SHALL be all-zero when req is all-zero.
REQ-014 Arbitration SHALL be round-robin: search starts at pointer rr_ptr and proceeds upward modulo NUM_REQ; first requester with req=1 wins.
REQ-015 On a grant to requester i, rr_ptr SHALL update to (i+1) mod NUM_REQ at the clock edge; with no grant, rr_ptr SHALL hold.
REQ-016 rom_addr SHALL equal addr slice of the granted requester in the grant cycle, and 0 when no grant.
REQ-017 Throughput SHALL be one grant per cycle, no bubbles, under continuous requests.
REQ-018 A two-stage tag pipeline (valid bit + requester index) SHALL track each grant: stage 1 loads at the grant edge, stage 2 loads from stage 1 at the next edge.
REQ-019 rdata SHALL register rom_data on the edge that loads tag stage 2; rdata_valid SHALL decode tag stage 2.
REQ-020 Latency: grant in cycle t -> rdata and rdata_valid asserted in cycle t+2, exactly one cycle wide.
REQ-021 rdata SHALL hold its last value when no rdata_valid bit is set.
REQ-022 Requests dropped before grant SHALL be ignored; no rdata_valid SHALL be produced for them.
REQ-023 A requester granted in consecutive cycles SHALL receive responses in consecutive cycles in grant order.
REQ-024 With NUM_REQ requesters continuously active, each SHALL be granted exactly once in every NUM_REQ consecutive cycles.

Reset
REQ-025 Reset high SHALL immediately clear rr_ptr to 0, both tag stages to invalid, rdata to 0, rdata_valid to 0.
REQ-026 Reset mid-operation SHALL discard in-flight reads; no rdata_valid SHALL assert for grants issued before or during reset.
REQ-027 gnt SHALL be all-zero while Reset is high regardless of req.
REQ-028 The first grant after reset release SHALL use rr_ptr=0.

Verification (ROM model: mem[a] = {a,a,a}, one-cycle registered read)
REQ-029 After reset, req=3'b001, addr0=8'h12 for one cycle -> gnt=3'b001 that cycle, rdata=24'h121212 with rdata_valid=3'b001 two cycles later, then rdata_valid=0.
REQ-030 req=3'b111 held 6 cycles, addr0/1/2=8'h01/8'h02/8'h03 -> gnt sequence 001,010,100,001,010,100; rdata sequence 010101,020202,030303 repeated, starting 2 cycles after first grant.
REQ-031 rr_ptr=2 then req=3'b011 -> gnt=3'b001 (wrap-around), next cycle gnt=3'b010.
REQ-032 Grant to requester 1 addr 8'h40, Reset pulsed one cycle later -> no rdata_valid ever for that read, rdata=0 after reset.
REQ-033 req=3'b000 for 10 cycles -> gnt=0, rom_addr=0, rdata_valid=0, rr_ptr unchanged.
REQ-034 Requester 2 alone, addr stepping 8'hFE, 8'hFF, 8'h00 on consecutive grants -> rdata FEFEFE, FFFFFF, 000000 on three consecutive cycles, each with rdata_valid=3'b100.

Source files
------------

// File: rtl/rom_read_arbiter.sv
// rom_read_arbiter
//   Shares one registered-output ROM read port among NUM_REQ requesters.
//   Grants are round-robin, one per cycle, and each grant returns its ROM
//   word to the owning requester exactly two cycles after the grant cycle.
//
// Ports
//   Clk          in   clock, all state updates on the rising edge
//   Reset        in   asynchronous active-high reset
//   req          in   [NUM_REQ]         per-requester read request
//   addr         in   [NUM_REQ*ADDR_W]  flattened request addresses
//   gnt          out  [NUM_REQ]         one-hot combinational grant
//   rom_addr     out  [ADDR_W]          address presented to the shared ROM
//   rom_data     in   [DATA_W]          ROM registered read data
//   rdata        out  [DATA_W]          registered read data
//   rdata_valid  out  [NUM_REQ]         one-hot owner of rdata, one cycle wide
module rom_read_arbiter #(
  parameter int NUM_REQ = 3,
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 24
) (
  input  logic                        Clk,
  input  logic                        Reset,
  input  logic [NUM_REQ-1:0]          req,
  input  logic [NUM_REQ*ADDR_W-1:0]   addr,
  output logic [NUM_REQ-1:0]          gnt,
  output logic [ADDR_W-1:0]           rom_addr,
  input  logic [DATA_W-1:0]           rom_data,
  output logic [DATA_W-1:0]           rdata,
  output logic [NUM_REQ-1:0]          rdata_valid
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [PTR_W:0]   NUM_REQ_X = (PTR_W+1)'(NUM_REQ);
  localparam logic [PTR_W-1:0] LAST_IDX  = PTR_W'(NUM_REQ - 1);

  // State
  logic [PTR_W-1:0]  rr_ptr_q,   rr_ptr_d;
  logic              tag1_vld_q, tag1_vld_d;
  logic [PTR_W-1:0]  tag1_idx_q, tag1_idx_d;
  logic              tag2_vld_q, tag2_vld_d;
  logic [PTR_W-1:0]  tag2_idx_q, tag2_idx_d;
  logic [DATA_W-1:0] rdata_q,    rdata_d;

  // Arbitration results
  logic [NUM_REQ-1:0] gnt_s;
  logic               gnt_vld_s;
  logic [PTR_W-1:0]   gnt_idx_s;
  logic [ADDR_W-1:0]  rom_addr_s;
  logic [PTR_W:0]     cand_s;

  // Round-robin search starting at rr_ptr_q; first active requester wins.
  // Grant is forced off while Reset is high so nothing can enter the pipe.
  always_comb begin
    gnt_s      = '0;
    gnt_vld_s  = 1'b0;
    gnt_idx_s  = '0;
    rom_addr_s = '0;
    cand_s     = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand_s = {1'b0, rr_ptr_q} + (PTR_W+1)'(k);
      if (cand_s >= NUM_REQ_X) begin
        cand_s = cand_s - NUM_REQ_X;
      end else begin
        cand_s = cand_s;
      end
      if (!gnt_vld_s && req[cand_s[PTR_W-1:0]]) begin
        gnt_vld_s = 1'b1;
        gnt_idx_s = cand_s[PTR_W-1:0];
      end else begin
        gnt_vld_s = gnt_vld_s;
      end
    end
    if (Reset) begin
      gnt_vld_s = 1'b0;
      gnt_idx_s = '0;
    end else begin
      gnt_vld_s = gnt_vld_s;
    end
    if (gnt_vld_s) begin
      gnt_s                 = '0;
      gnt_s[gnt_idx_s]      = 1'b1;
      rom_addr_s            = addr[int'(gnt_idx_s)*ADDR_W +: ADDR_W];
    end else begin
      gnt_s      = '0;
      rom_addr_s = '0;
    end
  end

  // Next-state: pointer advance past the winner, two-stage tag pipe, data capture.
  always_comb begin
    rr_ptr_d   = rr_ptr_q;
    tag1_vld_d = gnt_vld_s;
    tag1_idx_d = gnt_idx_s;
    // Stage 2 follows stage 1 every edge; rom_data is valid in the cycle
    // stage 1 holds a valid tag, so that is the edge that captures it.
    tag2_vld_d = tag1_vld_q;
    tag2_idx_d = tag1_idx_q;
    rdata_d    = rdata_q;
    if (gnt_vld_s) begin
      if (gnt_idx_s == LAST_IDX) begin
        rr_ptr_d = '0;
      end else begin
        rr_ptr_d = gnt_idx_s + PTR_W'(1);
      end
    end else begin
      rr_ptr_d = rr_ptr_q;
    end
    if (tag1_vld_q) begin
      rdata_d = rom_data;
    end else begin
      rdata_d = rdata_q;
    end
  end

  // State registers; reset drops any in-flight reads immediately.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      rr_ptr_q   <= '0;
      tag1_vld_q <= 1'b0;
      tag1_idx_q <= '0;
      tag2_vld_q <= 1'b0;
      tag2_idx_q <= '0;
      rdata_q    <= '0;
    end else begin
      rr_ptr_q   <= rr_ptr_d;
      tag1_vld_q <= tag1_vld_d;
      tag1_idx_q <= tag1_idx_d;
      tag2_vld_q <= tag2_vld_d;
      tag2_idx_q <= tag2_idx_d;
      rdata_q    <= rdata_d;
    end
  end

  // Owner decode of the registered stage-2 tag.
  always_comb begin
    rdata_valid = '0;
    if (tag2_vld_q) begin
      rdata_valid[tag2_idx_q] = 1'b1;
    end else begin
      rdata_valid = '0;
    end
  end

  assign gnt      = gnt_s;
  assign rom_addr = rom_addr_s;
  assign rdata    = rdata_q;

endmodule

// File: tb/tb_rom_read_arbiter.sv
// tb_rom_read_arbiter
//   Directed stimulus with hand-computed grants; expected read responses
//   (owner, data, arrival cycle) are queued at grant time and a separate
//   monitor compares them when rdata_valid is seen.
module tb_rom_read_arbiter;

  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  logic [2:0]  req = 3'b000;
  logic [23:0] addr = 24'h000000;
  logic [2:0]  gnt;
  logic [7:0]  rom_addr;
  logic [23:0] rom_data = 24'h000000;
  logic [23:0] rdata;
  logic [2:0]  rdata_valid;

  typedef struct {
    int          cyc;
    logic [2:0]  owner;
    logic [23:0] data;
  } exp_t;

  exp_t        sb_q[$];
  int          checks = 0;
  int          failures = 0;
  int          cyc = 0;
  logic [23:0] last_data = 24'h000000;

  rom_read_arbiter #(.NUM_REQ(3), .ADDR_W(8), .DATA_W(24)) dut (
    .Clk(Clk), .Reset(Reset), .req(req), .addr(addr), .gnt(gnt),
    .rom_addr(rom_addr), .rom_data(rom_data), .rdata(rdata),
    .rdata_valid(rdata_valid)
  );

  always #5 Clk = ~Clk;

  // ROM model: mem[a] = {a,a,a}, one-cycle registered read.
  always @(posedge Clk) rom_data <= {rom_addr, rom_addr, rom_addr};

  always @(posedge Clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: compares responses against the scoreboard queue.
  always @(negedge Clk) begin
    if (Reset) begin
      chk("reset_rdata", rdata, 24'h000000);
      chk("reset_rdata_valid", rdata_valid, 3'b000);
      last_data = 24'h000000;
    end else if (rdata_valid != 3'b000) begin
      if (sb_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_rdata_valid: got %0h expected none (cycle %0d)", rdata_valid, cyc);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        chk("rdata_valid", rdata_valid, e.owner);
        chk("rdata", rdata, e.data);
        chk("latency_cycle", cyc, e.cyc);
        last_data = e.data;
      end
    end else begin
      chk("rdata_hold", rdata, last_data);
    end
  end

  // One stimulus cycle: drive, check grant/rom_addr, queue expected response.
  task automatic step(input logic [2:0] r, input logic [7:0] a0, input logic [7:0] a1,
                      input logic [7:0] a2, input logic [2:0] eg, input logic [7:0] ea,
                      input bit expect_resp);
    exp_t e;
    req  = r;
    addr = {a2, a1, a0};
    @(negedge Clk);
    chk("gnt", gnt, eg);
    chk("rom_addr", rom_addr, ea);
    if (expect_resp && eg != 3'b000) begin
      e.cyc   = cyc + 2;
      e.owner = eg;
      e.data  = {ea, ea, ea};
      sb_q.push_back(e);
    end
    @(posedge Clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(3'b000, 8'h00, 8'h00, 8'h00, 3'b000, 8'h00, 1'b1);
  endtask

  initial begin
    // Reset held with all requests high: no grant may appear.
    req = 3'b111;
    addr = 24'h030201;
    for (int i = 0; i < 2; i++) begin
      @(negedge Clk);
      chk("gnt_in_reset", gnt, 3'b000);
    end
    @(posedge Clk);
    #1;
    Reset = 1'b0;

    // Continuous requests: first grant uses pointer 0, strict rotation.
    step(3'b111, 8'h01, 8'h02, 8'h03, 3'b001, 8'h01, 1'b1);
    step(3'b111, 8'h01, 8'h02, 8'h03, 3'b010, 8'h02, 1'b1);
    step(3'b111, 8'h01, 8'h02, 8'h03, 3'b100, 8'h03, 1'b1);
    step(3'b111, 8'h01, 8'h02, 8'h03, 3'b001, 8'h01, 1'b1);
    step(3'b111, 8'h01, 8'h02, 8'h03, 3'b010, 8'h02, 1'b1);
    step(3'b111, 8'h01, 8'h02, 8'h03, 3'b100, 8'h03, 1'b1);
    idle(3);

    // Single read from requester 0 (pointer 0 -> 1).
    step(3'b001, 8'h12, 8'h00, 8'h00, 3'b001, 8'h12, 1'b1);
    idle(3);

    // Move pointer to 2, then wrap-around with req=011.
    step(3'b010, 8'h00, 8'h20, 8'h00, 3'b010, 8'h20, 1'b1);
    step(3'b011, 8'h30, 8'h31, 8'h00, 3'b001, 8'h30, 1'b1);
    step(3'b011, 8'h30, 8'h31, 8'h00, 3'b010, 8'h31, 1'b1);

    // Ten idle cycles; pointer must still be 2 afterwards.
    idle(10);
    step(3'b111, 8'h05, 8'h06, 8'h07, 3'b100, 8'h07, 1'b1);
    idle(3);

    // Requester 1 drops its request before being granted.
    step(3'b011, 8'h50, 8'h51, 8'h00, 3'b001, 8'h50, 1'b1);
    step(3'b100, 8'h00, 8'h00, 8'h52, 3'b100, 8'h52, 1'b1);
    idle(3);

    // Requester 2 alone, addresses wrapping through FF -> 00.
    step(3'b100, 8'h00, 8'h00, 8'hFE, 3'b100, 8'hFE, 1'b1);
    step(3'b100, 8'h00, 8'h00, 8'hFF, 3'b100, 8'hFF, 1'b1);
    step(3'b100, 8'h00, 8'h00, 8'h00, 3'b100, 8'h00, 1'b1);
    idle(3);

    // Grant to requester 1 then reset one cycle later: read must vanish.
    step(3'b010, 8'h00, 8'h40, 8'h00, 3'b010, 8'h40, 1'b0);
    req = 3'b000;
    Reset = 1'b1;
    @(negedge Clk);
    chk("gnt_in_reset2", gnt, 3'b000);
    @(posedge Clk);
    #1;
    Reset = 1'b0;
    idle(4);
    chk("rdata_after_reset", rdata, 24'h000000);

    // Pointer restarts at 0 after reset.
    step(3'b110, 8'h00, 8'h61, 8'h62, 3'b010, 8'h61, 1'b1);
    idle(3);

    chk("scoreboard_drained", sb_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
